// File: rtl/tensor_core_pkg.sv
// Shared opcode/opselect encodings, FSM state types and field positions for the
// tensor-core burst sequencer and its burst engine.
package tensor_core_pkg;

  localparam logic [1:0] OP_GENERIC             = 2'b00;
  localparam logic [1:0] OP_LOAD_IMMEDIATE      = 2'b01;
  localparam logic [1:0] OP_TENSOR_CORE_OPERATE = 2'b10;
  localparam logic [1:0] OP_BURST               = 2'b11;

  localparam logic [1:0] GENERIC_HALT  = 2'b10;
  localparam logic [1:0] GENERIC_RESET = 2'b11;

  localparam logic [1:0] BURST_READ           = 2'b00;
  localparam logic [1:0] BURST_WRITE          = 2'b01;
  localparam logic [1:0] BURST_READ_AND_WRITE = 2'b10;
  localparam logic [1:0] BURST_NOP            = 2'b11;

  localparam int OPERAND_LSB   = 4;
  localparam int LDI_HI_LSB    = 11;
  localparam int LDI_DATA_BITS = 8;
  localparam int LDI_LO_BITS   = 3;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_WAIT, S_DECODE, S_LDWAIT, S_ISSUE, S_BURST
  } seq_state_t;

  typedef enum logic [1:0] {W_ADDR, W_DATA, W_HOLD} wr_phase_t;

  typedef struct packed {
    logic rd;
    logic wr;
  } burst_mode_t;

  function automatic burst_mode_t burst_mode(input logic [1:0] sel);
    burst_mode_t m;
    m.rd = (sel == BURST_READ) || (sel == BURST_READ_AND_WRITE);
    m.wr = (sel == BURST_WRITE) || (sel == BURST_READ_AND_WRITE);
    return m;
  endfunction

endpackage

// File: rtl/tensor_core_burst_engine.sv
// Burst engine: streams BURST_BEATS data-RAM words to the core (write side) and
// stores BURST_BEATS core result beats to result RAM (read side), independently.
module tensor_core_burst_engine
  import tensor_core_pkg::*;
#(
  parameter int INSTR_WIDTH  = 16,
  parameter int DADDR_WIDTH  = 15,
  parameter int RESULT_WIDTH = 8,
  parameter int BURST_BEATS  = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [DADDR_WIDTH-1:0]  base,
  input  burst_mode_t             mode,
  input  logic [INSTR_WIDTH-1:0]  data_rd,
  input  logic                    tc_ready,
  input  logic [RESULT_WIDTH-1:0] tc_result,
  input  logic                    tc_result_valid,
  output logic [DADDR_WIDTH-1:0]  data_addr,
  output logic [INSTR_WIDTH-1:0]  word,
  output logic                    valid,
  output logic                    result_wr_en,
  output logic [DADDR_WIDTH-1:0]  result_addr,
  output logic [RESULT_WIDTH-1:0] result_data,
  output logic                    done
);

  localparam int CW = $clog2(BURST_BEATS + 1);
  localparam logic [CW-1:0] BEATS = CW'(BURST_BEATS);

  logic                   active, rd_en, wr_en;
  logic [DADDR_WIDTH-1:0] base_q;
  logic [CW-1:0]          wcnt, rcnt;
  logic [CW-1:0]          wcnt_inc;
  wr_phase_t              wphase;
  logic                   wr_fin, rd_fin;

  assign wcnt_inc = wcnt + 1'b1;
  assign wr_fin   = !wr_en || (wcnt == BEATS);
  assign rd_fin   = !rd_en || (rcnt == BEATS);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active       <= 1'b0;
      rd_en        <= 1'b0;
      wr_en        <= 1'b0;
      base_q       <= '0;
      wcnt         <= '0;
      rcnt         <= '0;
      wphase       <= W_ADDR;
      data_addr    <= '0;
      word         <= '0;
      valid        <= 1'b0;
      result_wr_en <= 1'b0;
      result_addr  <= '0;
      result_data  <= '0;
      done         <= 1'b0;
    end else begin
      done         <= 1'b0;
      result_wr_en <= 1'b0;
      if (start) begin
        active    <= 1'b1;
        rd_en     <= mode.rd;
        wr_en     <= mode.wr;
        base_q    <= base;
        wcnt      <= '0;
        rcnt      <= '0;
        wphase    <= W_ADDR;
        data_addr <= base;
      end else if (active) begin
        if (wr_fin && rd_fin) begin
          active <= 1'b0;
          done   <= 1'b1;
        end
        // Each write beat: address cycle, data cycle, then hold until accepted.
        if (!wr_fin) begin
          case (wphase)
            W_ADDR: wphase <= W_DATA;
            W_DATA: begin
              word   <= data_rd;
              valid  <= 1'b1;
              wphase <= W_HOLD;
            end
            W_HOLD: if (tc_ready) begin
              valid  <= 1'b0;
              wcnt   <= wcnt_inc;
              wphase <= W_ADDR;
              if (wcnt_inc != BEATS) data_addr <= base_q + DADDR_WIDTH'(wcnt_inc);
            end
            default: wphase <= W_ADDR;
          endcase
        end
        if (!rd_fin && tc_result_valid) begin
          result_wr_en <= 1'b1;
          result_addr  <= base_q + DADDR_WIDTH'(rcnt);
          result_data  <= tc_result;
          rcnt         <= rcnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/tensor_core_burst_sequencer.sv
// Instruction sequencer: fetches/decodes ROM words, resolves LOAD_IMMEDIATE
// operands, issues words to the tensor core and hands bursts to the engine.
module tensor_core_burst_sequencer
  import tensor_core_pkg::*;
#(
  parameter int INSTR_WIDTH    = 16,
  parameter int IADDR_WIDTH    = 15,
  parameter int DADDR_WIDTH    = 15,
  parameter int RESULT_WIDTH   = 8,
  parameter int BURST_BEATS    = 5,
  parameter int PROGRAM_LENGTH = 20000
) (
  input  logic                    clock_in,
  input  logic                    reset_in,
  input  logic                    start_in,
  output logic [IADDR_WIDTH-1:0]  instr_addr_out,
  input  logic [INSTR_WIDTH-1:0]  instr_data_in,
  output logic [DADDR_WIDTH-1:0]  data_addr_out,
  input  logic [INSTR_WIDTH-1:0]  data_rd_in,
  output logic                    result_wr_en_out,
  output logic [DADDR_WIDTH-1:0]  result_addr_out,
  output logic [RESULT_WIDTH-1:0] result_data_out,
  output logic [INSTR_WIDTH-1:0]  tc_instruction_out,
  output logic                    tc_valid_out,
  input  logic                    tc_ready_in,
  input  logic [RESULT_WIDTH-1:0] tc_result_in,
  input  logic                    tc_result_valid_in,
  output logic                    busy_out,
  output logic                    done_out
);

  localparam logic [IADDR_WIDTH:0] PLEN = (IADDR_WIDTH + 1)'(PROGRAM_LENGTH);

  seq_state_t             state;
  logic [IADDR_WIDTH-1:0] pc;
  logic [INSTR_WIDTH-1:0] instr, seq_word, eng_word;
  logic                   seq_valid, eng_valid, eng_done, tc_sel, done, advance;
  logic [DADDR_WIDTH-1:0] ld_addr, eng_daddr;
  logic [IADDR_WIDTH:0]   pc_next;
  logic [1:0]             opcode, opsel;
  logic                   eng_start;
  burst_mode_t            mode;

  assign opcode    = instr[1:0];
  assign opsel     = instr[3:2];
  assign pc_next   = {1'b0, pc} + 1'b1;
  assign mode      = burst_mode(opsel);
  assign eng_start = (state == S_DECODE) && (opcode == OP_BURST) && (opsel != BURST_NOP);

  always_comb begin
    advance = 1'b0;
    case (state)
      S_DECODE: advance = (opcode == OP_GENERIC && opsel == GENERIC_RESET) ||
                          (opcode == OP_BURST && opsel == BURST_NOP);
      S_ISSUE:  advance = tc_ready_in;
      S_BURST:  advance = eng_done;
      default:  advance = 1'b0;
    endcase
  end

  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      state     <= S_IDLE;
      pc        <= '0;
      instr     <= '0;
      seq_word  <= '0;
      seq_valid <= 1'b0;
      ld_addr   <= '0;
      tc_sel    <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (advance) begin
        seq_valid <= 1'b0;
        if (pc_next == PLEN) begin
          state <= S_IDLE;
          done  <= 1'b1;
        end else begin
          pc    <= pc_next[IADDR_WIDTH-1:0];
          state <= S_FETCH;
        end
      end else begin
        case (state)
          S_IDLE: if (start_in) begin
            pc    <= '0;
            state <= S_FETCH;
          end
          S_FETCH: state <= S_WAIT;
          S_WAIT: begin
            instr <= instr_data_in;
            // Present the operand address early so the RAM word lands in LDWAIT.
            if (instr_data_in[1:0] == OP_LOAD_IMMEDIATE) begin
              ld_addr <= DADDR_WIDTH'(instr_data_in[INSTR_WIDTH-1:OPERAND_LSB]);
              tc_sel  <= 1'b0;
            end
            state <= S_DECODE;
          end
          S_DECODE: begin
            case (opcode)
              OP_GENERIC: if (opsel == GENERIC_HALT) begin
                state <= S_IDLE;
                done  <= 1'b1;
              end else begin
                seq_word  <= instr;
                seq_valid <= 1'b1;
                tc_sel    <= 1'b0;
                state     <= S_ISSUE;
              end
              OP_LOAD_IMMEDIATE: state <= S_LDWAIT;
              OP_TENSOR_CORE_OPERATE: begin
                seq_word  <= instr;
                seq_valid <= 1'b1;
                tc_sel    <= 1'b0;
                state     <= S_ISSUE;
              end
              default: begin
                if (mode.wr) tc_sel <= 1'b1;
                state <= S_BURST;
              end
            endcase
          end
          S_LDWAIT: begin
            seq_word  <= {instr[INSTR_WIDTH-1:LDI_HI_LSB], data_rd_in[LDI_DATA_BITS-1:0],
                          instr[LDI_LO_BITS-1:0]};
            seq_valid <= 1'b1;
            state     <= S_ISSUE;
          end
          default: state <= state;
        endcase
      end
    end
  end

  tensor_core_burst_engine #(
    .INSTR_WIDTH (INSTR_WIDTH),
    .DADDR_WIDTH (DADDR_WIDTH),
    .RESULT_WIDTH(RESULT_WIDTH),
    .BURST_BEATS (BURST_BEATS)
  ) u_engine (
    .clk            (clock_in),
    .rst            (reset_in),
    .start          (eng_start),
    .base           (DADDR_WIDTH'(instr[INSTR_WIDTH-1:OPERAND_LSB])),
    .mode           (mode),
    .data_rd        (data_rd_in),
    .tc_ready       (tc_ready_in),
    .tc_result      (tc_result_in),
    .tc_result_valid(tc_result_valid_in),
    .data_addr      (eng_daddr),
    .word           (eng_word),
    .valid          (eng_valid),
    .result_wr_en   (result_wr_en_out),
    .result_addr    (result_addr_out),
    .result_data    (result_data_out),
    .done           (eng_done)
  );

  // The core word and data address follow whichever side last drove them, so
  // tc_instruction_out keeps its value while tc_valid_out is low.
  assign instr_addr_out     = pc;
  assign data_addr_out      = tc_sel ? eng_daddr : ld_addr;
  assign tc_instruction_out = tc_sel ? eng_word : seq_word;
  assign tc_valid_out       = seq_valid | eng_valid;
  assign busy_out           = (state != S_IDLE);
  assign done_out           = done;

endmodule

// File: tb/tb_tensor_core_burst_sequencer.sv
// Directed bench for tensor_core_burst_sequencer: single-instruction vector
// table plus hand-written burst and mid-burst reset sequences.
module tb_tensor_core_burst_sequencer;

  logic        clock_in = 1'b0, reset_in = 1'b1, start_in = 1'b0;
  logic [14:0] instr_addr_out, data_addr_out, result_addr_out;
  logic [15:0] instr_data_in = '0, data_rd_in = '0, tc_instruction_out;
  logic        result_wr_en_out, tc_valid_out, busy_out, done_out;
  logic [7:0]  result_data_out, tc_result_in = '0;
  logic        tc_ready_in = 1'b1, tc_result_valid_in = 1'b0;

  tensor_core_burst_sequencer dut (
    .clock_in(clock_in), .reset_in(reset_in), .start_in(start_in),
    .instr_addr_out(instr_addr_out), .instr_data_in(instr_data_in),
    .data_addr_out(data_addr_out), .data_rd_in(data_rd_in),
    .result_wr_en_out(result_wr_en_out), .result_addr_out(result_addr_out),
    .result_data_out(result_data_out), .tc_instruction_out(tc_instruction_out),
    .tc_valid_out(tc_valid_out), .tc_ready_in(tc_ready_in), .tc_result_in(tc_result_in),
    .tc_result_valid_in(tc_result_valid_in), .busy_out(busy_out), .done_out(done_out)
  );

  always #5 clock_in = ~clock_in;

  logic [15:0] rom  [0:63];
  logic [15:0] dmem [0:4095];
  logic [7:0]  rres [0:4095];

  always @(posedge clock_in) begin
    instr_data_in <= rom[instr_addr_out[5:0]];
    data_rd_in    <= dmem[data_addr_out[11:0]];
  end

  int          cyc = 0, nres = 0, vcnt = 0, hold_err = 0, last_acc = -1;
  logic [15:0] acc[$];
  logic        pv = 1'b0, pr = 1'b0;
  logic [15:0] pw = '0;

  always @(posedge clock_in) begin
    cyc++;
    if (reset_in) pv = 1'b0;
    else begin
      if (pv && !pr && (!tc_valid_out || tc_instruction_out != pw)) hold_err++;
      if (tc_valid_out) vcnt++;
      if (tc_valid_out && tc_ready_in) begin
        acc.push_back(tc_instruction_out);
        last_acc = cyc;
      end
      if (result_wr_en_out) begin
        rres[result_addr_out[11:0]] = result_data_out;
        nres++;
      end
      pv = tc_valid_out; pr = tc_ready_in; pw = tc_instruction_out;
    end
  end

  int total = 0, bad = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic clear();
    acc.delete();
    nres = 0; vcnt = 0; hold_err = 0; last_acc = -1;
  endtask

  // rmode: 0 ready high, 1 toggling, 2 high one cycle in four.
  task automatic run(input int rmode, input int bfirst, input int bgap, input int bn,
                     input logic [7:0] bbase, input int s1, input int s2,
                     output int done_at, output int dcnt, output int t0);
    int rel, d;
    done_at = -1; dcnt = 0;
    @(negedge clock_in);
    start_in = 1'b1; tc_ready_in = (rmode != 2); t0 = cyc;
    for (int k = 0; k < 400; k++) begin
      @(negedge clock_in);
      start_in = 1'b0;
      rel = cyc - t0;
      case (rmode)
        0: tc_ready_in = 1'b1;
        1: tc_ready_in = ~tc_ready_in;
        default: tc_ready_in = (rel % 4 == 0);
      endcase
      d = rel - bfirst;
      if (bn > 0 && d >= 0 && d % bgap == 0 && d / bgap < bn) begin
        tc_result_valid_in = 1'b1; tc_result_in = bbase + 8'(d / bgap);
      end else if (rel == s1 || rel == s2) begin
        tc_result_valid_in = 1'b1; tc_result_in = 8'h99;
      end else tc_result_valid_in = 1'b0;
      if (done_out) begin
        dcnt++;
        if (done_at < 0) done_at = rel;
      end
      if (done_at >= 0 && rel >= done_at + 6 && rel > s2) break;
    end
    tc_result_valid_in = 1'b0;
    tc_ready_in = 1'b1;
    if (done_at < 0) begin
      total++; bad++;
      $display("FAIL run_timeout got=no_done exp=done");
    end
  endtask

  typedef struct {
    string       name;
    logic [15:0] instr;
    logic        ld;
    logic [15:0] ld_data;
    int          exp_n;
    logic [15:0] exp_word;
    int          exp_lat;
  } vec_t;

  vec_t vt[9];

  initial begin
    int done_at, dcnt, t0;
    logic [14:0] exp_da;
    logic [15:0] exp_q[$];

    vt[0] = '{"operate",    16'h0012, 1'b0, 16'h0000, 1, 16'h0012, 8};
    vt[1] = '{"ldi_800",    16'h8005, 1'b1, 16'h00AB, 1, 16'h855D, 9};
    vt[2] = '{"gen_pass00", 16'h0000, 1'b0, 16'h0000, 1, 16'h0000, 8};
    vt[3] = '{"gen_pass01", 16'h0004, 1'b0, 16'h0000, 1, 16'h0004, 8};
    vt[4] = '{"gen_reset",  16'h000C, 1'b0, 16'h0000, 0, 16'h0000, 7};
    vt[5] = '{"burst_nop",  16'h000F, 1'b0, 16'h0000, 0, 16'h0000, 7};
    vt[6] = '{"ldi_123",    16'h1235, 1'b1, 16'h7F3C, 1, 16'h11E5, 9};
    vt[7] = '{"operate_ff", 16'hFFFE, 1'b0, 16'h0000, 1, 16'hFFFE, 8};
    vt[8] = '{"halt_first", 16'h0008, 1'b0, 16'h0000, 0, 16'h0000, 4};

    for (int i = 0; i < 64; i++) rom[i] = '0;
    for (int i = 0; i < 4096; i++) begin dmem[i] = '0; rres[i] = '0; end

    repeat (2) @(negedge clock_in);
    chk("reset_outputs", {instr_addr_out, data_addr_out, result_wr_en_out, result_addr_out,
        result_data_out, tc_instruction_out, tc_valid_out, busy_out, done_out}, 0);
    reset_in = 1'b0;
    @(negedge clock_in);
    chk("idle_busy", busy_out, 0);

    exp_da = '0;
    for (int i = 0; i < 9; i++) begin
      rom[0] = vt[i].instr; rom[1] = 16'h0008;
      if (vt[i].ld) begin
        dmem[vt[i].instr[15:4]] = vt[i].ld_data;
        exp_da = 15'(vt[i].instr[15:4]);
      end
      clear();
      run(0, 0, 1, 0, 8'h00, -1, -1, done_at, dcnt, t0);
      chk({vt[i].name, "_latency"}, done_at, vt[i].exp_lat);
      chk({vt[i].name, "_nwords"}, acc.size(), vt[i].exp_n);
      chk({vt[i].name, "_valid_cycles"}, vcnt, vt[i].exp_n);
      if (vt[i].exp_n > 0 && acc.size() > 0) chk({vt[i].name, "_word"}, acc[0], vt[i].exp_word);
      chk({vt[i].name, "_data_addr"}, data_addr_out, exp_da);
      chk({vt[i].name, "_done_pulses"}, dcnt, 1);
      chk({vt[i].name, "_busy_after"}, busy_out, 0);
    end

    // Write burst with ready toggling.
    rom[0] = 16'h0107; rom[1] = 16'h0008;
    for (int k = 0; k < 5; k++) dmem[16 + k] = 16'(k + 1);
    clear();
    run(1, 0, 1, 0, 8'h00, -1, -1, done_at, dcnt, t0);
    chk("bw_nwords", acc.size(), 5);
    for (int k = 0; k < 5; k++) if (acc.size() > k) chk("bw_word", acc[k], k + 1);
    chk("bw_hold_stable", hold_err, 0);
    chk("bw_no_results", nres, 0);
    chk("bw_busy_after", busy_out, 0);

    // Read burst, beats every 2 cycles, strays before and after.
    rom[0] = 16'h0203;
    clear();
    run(0, 5, 2, 5, 8'h11, 2, 22, done_at, dcnt, t0);
    chk("br_nres", nres, 5);
    for (int k = 0; k < 5; k++) chk("br_data", rres[12'h020 + 12'(k)], 8'h11 + 8'(k));
    chk("br_below", rres[12'h01F], 0);
    chk("br_above", rres[12'h025], 0);
    chk("br_no_valid", vcnt, 0);
    chk("br_done_at", done_at, 19);

    // Read+write burst: results finish well before the slow write side.
    rom[0] = 16'h030B;
    for (int k = 0; k < 5; k++) dmem[48 + k] = 16'h00A0 + 16'(k);
    clear();
    run(2, 5, 1, 5, 8'h61, -1, -1, done_at, dcnt, t0);
    exp_q = '{16'h00A0, 16'h00A1, 16'h00A2, 16'h00A3, 16'h00A4};
    chk("brw_nwords", acc.size(), 5);
    for (int k = 0; k < 5; k++) if (acc.size() > k) chk("brw_word", acc[k], exp_q[k]);
    chk("brw_nres", nres, 5);
    for (int k = 0; k < 5; k++) chk("brw_data", rres[12'h030 + 12'(k)], 8'h61 + 8'(k));
    chk("brw_exit_after_last_accept", (t0 + done_at) - last_acc, 5);
    chk("brw_hold_stable", hold_err, 0);

    // Reset asserted while write beat 2 is presented.
    rom[0] = 16'h030B;
    clear();
    @(negedge clock_in);
    start_in = 1'b1; tc_ready_in = 1'b1;
    @(negedge clock_in);
    start_in = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (acc.size() == 1 && tc_valid_out) break;
      @(negedge clock_in);
    end
    chk("rst_reached_beat2", {31'd0, tc_valid_out} + acc.size(), 2);
    reset_in = 1'b1;
    #1;
    chk("rst_outputs_now", {instr_addr_out, data_addr_out, result_wr_en_out, result_addr_out,
        result_data_out, tc_instruction_out, tc_valid_out, busy_out, done_out}, 0);
    tc_result_valid_in = 1'b1; tc_result_in = 8'h5A;
    repeat (2) @(negedge clock_in);
    reset_in = 1'b0;
    repeat (10) @(negedge clock_in);
    chk("rst_stays_idle", busy_out, 0);
    chk("rst_no_result_write", nres, 0);
    chk("rst_no_more_words", acc.size(), 1);
    tc_result_valid_in = 1'b0;

    rom[0] = 16'h0012;
    clear();
    run(0, 0, 1, 0, 8'h00, -1, -1, done_at, dcnt, t0);
    chk("restart_nwords", acc.size(), 1);
    if (acc.size() > 0) chk("restart_word", acc[0], 16'h0012);
    chk("restart_latency", done_at, 8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
